// File: rtl/fifo_middle_rr.sv
// Round-robin mover from NUM_CH upstream pop-side FIFOs into one downstream push-side FIFO.
// Reads in flight are credit-counted against a skid buffer, so a downstream stall never drops a word.
module fifo_middle_rr #(
  parameter int WIDTH      = 32,
  parameter int NUM_CH     = 4,
  parameter int RD_LAT     = 1,
  parameter int SKID_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         up_empty_i,
  output logic [NUM_CH-1:0]         up_pop_o,
  input  logic [NUM_CH-1:0]         up_valid_i,
  input  logic [NUM_CH*WIDTH-1:0]   up_data_i,
  input  logic                      dn_full_i,
  output logic                      dn_push_o,
  output logic [WIDTH-1:0]          dn_data_o,
  output logic [$clog2(NUM_CH)-1:0] dn_ch_o,
  output logic                      idle_o,
  output logic                      err_o
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int INF_W = $clog2(RD_LAT + 1);

  logic [CH_W-1:0]  last_q, last_d;
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             err_q, err_d;

  logic [RD_LAT-1:0] pv_q;
  logic [CH_W-1:0]   pc_q [RD_LAT];

  logic [WIDTH-1:0] mem_data_q [SKID_DEPTH];
  logic [CH_W-1:0]  mem_ch_q   [SKID_DEPTH];

  logic             gnt_found;
  logic [CH_W-1:0]  gnt_ch;
  logic             may_pop;
  logic             pop_en;
  logic             exit_vld;
  logic [CH_W-1:0]  exit_ch;
  logic [WIDTH-1:0] exit_data;
  logic [NUM_CH-1:0] exit_mask;
  logic             cap;
  logic             push;
  logic [31:0]      occ;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Search starts one past the last granted channel, giving cyclic fairness.
  always_comb begin
    int idx;
    logic [CH_W-1:0] idx_c;
    gnt_found = 1'b0;
    gnt_ch    = '0;
    idx       = 0;
    idx_c     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx   = (int'(last_q) + k) % NUM_CH;
      idx_c = CH_W'(idx);
      if (!gnt_found && !up_empty_i[idx_c]) begin
        gnt_found = 1'b1;
        gnt_ch    = idx_c;
      end
    end
  end

  // Credit uses registered occupancy only; a word leaving this cycle frees no slot yet.
  always_comb begin
    occ     = 32'(cnt_q) + 32'(inflight_q);
    may_pop = (occ < 32'(SKID_DEPTH));
    pop_en  = gnt_found & may_pop;
    up_pop_o = '0;
    if (pop_en) up_pop_o[gnt_ch] = 1'b1;
  end

  always_comb begin
    exit_vld  = pv_q[RD_LAT-1];
    exit_ch   = pc_q[RD_LAT-1];
    exit_data = '0;
    exit_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (exit_ch == CH_W'(i)) exit_data = up_data_i[i*WIDTH +: WIDTH];
    end
    if (exit_vld) exit_mask[exit_ch] = 1'b1;
    cap = exit_vld & up_valid_i[exit_ch];
  end

  always_comb begin
    push       = (cnt_q != '0) & ~dn_full_i;
    dn_push_o  = push;
    dn_data_o  = (cnt_q != '0) ? mem_data_q[rd_ptr_q] : '0;
    dn_ch_o    = (cnt_q != '0) ? mem_ch_q[rd_ptr_q] : '0;
    idle_o     = (cnt_q == '0) & (inflight_q == '0);
    err_o      = err_q;

    last_d     = pop_en ? gnt_ch : last_q;
    inflight_d = inflight_q + INF_W'(pop_en) - INF_W'(exit_vld);
    cnt_d      = cnt_q + CNT_W'(cap) - CNT_W'(push);
    wr_ptr_d   = cap  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = push ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    // A missing valid drops the entry but still returns its credit via inflight_d.
    err_d      = err_q | (exit_vld & ~up_valid_i[exit_ch]) | (|(up_valid_i & ~exit_mask));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= CH_W'(NUM_CH - 1);
      inflight_q <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
      pv_q       <= '0;
      for (int s = 0; s < RD_LAT; s++) pc_q[s] <= '0;
    end else begin
      last_q     <= last_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_q      <= err_d;
      pv_q[0]    <= pop_en;
      pc_q[0]    <= gnt_ch;
      for (int s = 1; s < RD_LAT; s++) begin
        pv_q[s] <= pv_q[s-1];
        pc_q[s] <= pc_q[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < SKID_DEPTH; e++) begin
        mem_data_q[e] <= '0;
        mem_ch_q[e]   <= '0;
      end
    end else if (cap) begin
      mem_data_q[wr_ptr_q] <= exit_data;
      mem_ch_q[wr_ptr_q]   <= exit_ch;
    end
  end

endmodule
